imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Loads the program image into the multicycle CPU's 128-word instruction memory from a byte stream, such as a UART receiver.
- Arbitrates that memory between itself and CPU instruction fetch.
- Holds the CPU in reset until a complete image with a correct checksum has been written.
- Sits between the UART RX block, the instruction RAM (write port plus read port) and the CPU top.

Parameters:
ADDR_W, 7, word-address width of instruction memory (depth 2**ADDR_W = 128)
TIMEOUT_CYC, 1_000_000, maximum idle clocks between bytes once a frame has started
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
reload  in  1  one-cycle pulse; restarts loading from DONE or ERROR
cpu_addr  in  32  CPU fetch byte address
instr  out  32  instruction returned to CPU
mem_raddr  out  ADDR_W  memory read word address
mem_rdata  in  32  memory read data (combinational read)
mem_we  out  1  memory write enable
mem_waddr  out  ADDR_W  memory write word address
mem_wdata  out  32  memory write data
cpu_hold  out  1  high = CPU held in reset
load_done  out  1  image loaded and checksum verified
load_err  out  1  frame error latched

Behaviour:
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN*4 payload bytes, then CSUM.
  - LEN is a 16-bit word count.
  - CSUM is the XOR of all payload bytes.
  - Payload words are little-endian: the first byte goes to bits 7:0.
- Reset values: state IDLE, cpu_hold=1, load_done=0, load_err=0, mem_we=0, mem_waddr=0, mem_wdata=0, byte/word counters and checksum cleared. Reset mid-frame abandons the frame; words already written are not cleared.
- rx_data is sampled only when rx_valid=1. There is no back-pressure; every byte is consumed in its strobe cycle.
- States:
  - IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE -> LEN_LO.
  - LEN_LO: store the low byte -> LEN_HI.
  - LEN_HI: form LEN. If LEN==0 or LEN>2**ADDR_W -> ERROR; otherwise clear the word index and checksum -> DATA.
  - DATA: accumulate bytes and XOR each into the checksum. On the 4th byte of a word, register mem_we=1 for exactly one cycle on the next clock, with mem_waddr = word index and mem_wdata = the assembled word. After word LEN-1 -> CSUM.
  - CSUM: byte == checksum -> DONE; otherwise -> ERROR.
  - DONE: cpu_hold=0, load_done=1. Further rx bytes are ignored. reload -> IDLE with cpu_hold=1 and load_done=0.
  - ERROR: load_err=1, cpu_hold=1. reload -> IDLE and clears load_err.
- Timeout: in LEN_LO, LEN_HI, DATA and CSUM, an idle counter resets on each rx_valid. Reaching TIMEOUT_CYC -> ERROR. The counter is inactive in IDLE, DONE and ERROR.
- Output timing: cpu_hold, load_done and load_err are registered and change one clock after the state transition that causes them.
- Arbitration and fetch path:
  - mem_raddr = cpu_addr[ADDR_W+1:2] at all times.
  - instr = mem_rdata when cpu_hold=0, otherwise 32'h00000013 (NOP).
  - The write port is driven only by the loader, and only while not in DONE.
- Simultaneous events:
  - reload in any state other than DONE or ERROR is ignored.
  - reload together with rx_valid in DONE: reload takes effect and that byte is dropped, even if it is SYNC_BYTE.
  - A timeout and an rx_valid in the same cycle: the byte wins and the counter resets.
- Word index is ADDR_W+1 bits wide, so LEN=128 terminates without wrap. An invalid LEN guarantees no write beyond the memory depth.

Decomposition:
- Package imem_boot_pkg:
  - state enum {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR};
  - SYNC_BYTE default;
  - NOP_INSTR = 32'h00000013.
- One sub-module, byte_word_packer: shifts in bytes, counts 0..3, emits word_valid together with the word. It is cleared by the FSM at LEN_HI and on reset.

Test Plan:
- Sync and tiny image: A5, 01, 00, 13, 00, 00, 00, CSUM=13.
  - One mem_we pulse, addr 0, data 32'h00000013.
  - DONE; cpu_hold falls and load_done=1.
  - instr then follows mem_rdata.
- Full image of 128 words (LEN bytes 80,00) with a correct XOR checksum: 128 writes at addresses 0..127 in order, no write at addr 0 after index 127, load_done=1.
- Bad checksum (A5,01,00,11,22,33,44,CSUM=00): word 32'h44332211 written, then ERROR; load_err=1, cpu_hold stays 1, instr=32'h00000013. reload -> IDLE with load_err=0.
- LEN=0 and LEN=129 (81,00): ERROR right after LEN_HI, zero mem_we pulses.
- Timeout: stop after 2 payload bytes with TIMEOUT_CYC=100 in the bench. ERROR on cycle 100 after the last byte; a byte arriving at cycle 99 resets the count.
- Reset mid-DATA: assert reset for 3 cycles after 5 bytes. Outputs return to reset values; garbage before A5 is ignored; a new full frame then loads correctly.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [31:0] NOP_INSTR         = 32'h00000013;
endpackage

// File: rtl/imem_boot_loader_packer.sv
// Assembles four little-endian bytes into one 32-bit word.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  cnt;
  logic [23:0] sh;

  // Earlier bytes shift down so byte 0 ends up in bits 7:0.
  assign word_valid = in_valid && (cnt == 2'd3);
  assign word       = {in_byte, sh};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clear) begin
      cnt <= '0;
      sh  <= '0;
    end else if (in_valid) begin
      cnt <= cnt + 2'd1;
      sh  <= {in_byte, sh[23:8]};
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Loads a checksummed byte-stream image into instruction memory and holds the CPU until it is valid.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              reload,
  input  logic [31:0]       cpu_addr,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int IDX_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nxt;
  logic [7:0]        len_lo, csum;
  logic [15:0]       len;
  logic [IDX_W-1:0]  word_idx, last_idx;
  logic [CNT_W-1:0]  idle_cnt;
  logic              len_bad, cnt_on, timeout;
  logic              pk_clear, pk_in, pk_valid;
  logic [31:0]       pk_word;
  logic              unused_addr;

  assign mem_raddr   = cpu_addr[ADDR_W+1:2];
  assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
  assign instr       = cpu_hold ? NOP_INSTR : mem_rdata;

  assign len     = {rx_data, len_lo};
  assign len_bad = (len == 16'd0) || (len > 16'(DEPTH));
  assign cnt_on  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = cnt_on && !rx_valid && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  assign pk_clear = (state == LEN_HI) && rx_valid;
  assign pk_in    = (state == DATA) && rx_valid;

  byte_word_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .in_valid   (pk_in),
    .in_byte    (rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_nxt = state;
    if (timeout) state_nxt = ERROR;
    else begin
      case (state)
        IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_nxt = LEN_LO;
        LEN_LO:  if (rx_valid) state_nxt = LEN_HI;
        LEN_HI:  if (rx_valid) state_nxt = len_bad ? ERROR : DATA;
        DATA:    if (pk_valid && word_idx == last_idx) state_nxt = CSUM;
        CSUM:    if (rx_valid) state_nxt = (rx_data == csum) ? DONE : ERROR;
        DONE:    if (reload) state_nxt = IDLE;
        ERROR:   if (reload) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      len_lo    <= '0;
      csum      <= '0;
      word_idx  <= '0;
      last_idx  <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cpu_hold  <= (state != DONE);
      load_done <= (state == DONE);
      load_err  <= (state == ERROR);
      idle_cnt  <= (!cnt_on || rx_valid) ? '0 : idle_cnt + 1'b1;
      mem_we    <= 1'b0;
      if (state == LEN_LO && rx_valid) len_lo <= rx_data;
      if (pk_clear) begin
        word_idx <= '0;
        csum     <= '0;
        last_idx <= IDX_W'(len - 16'd1);
      end
      if (pk_in) csum <= csum ^ rx_data;
      if (pk_in && pk_valid) begin
        mem_we    <= 1'b1;
        mem_waddr <= word_idx[ADDR_W-1:0];
        mem_wdata <= pk_word;
        word_idx  <= word_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a behavioural instruction RAM and write log.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        reset, rx_valid, reload;
  logic [7:0]  rx_data;
  logic [31:0] cpu_addr, instr, mem_rdata, mem_wdata;
  logic [6:0]  mem_raddr, mem_waddr;
  logic        mem_we, cpu_hold, load_done, load_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m  [0:127]  = '{default: 32'hCAFEF00D};
  logic [6:0]  wa [0:1023] = '{default: 7'd0};
  logic [31:0] wd [0:1023] = '{default: 32'd0};
  int          wr_total    = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(7), .TIMEOUT_CYC(100), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .reload(reload),
    .cpu_addr(cpu_addr), .instr(instr), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  assign mem_rdata = m[mem_raddr];

  always @(posedge clk) begin
    if (mem_we) begin
      m[mem_waddr]  <= mem_wdata;
      wa[wr_total]  <= mem_waddr;
      wd[wr_total]  <= mem_wdata;
      wr_total      <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base, bad;
    logic [7:0] cs, b0, b1;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0; cpu_addr = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_instr", instr, 32'h00000013);
    cpu_addr = 32'h000001FC; #1;
    chk("raddr_127", {25'd0, mem_raddr}, 32'd127);
    cpu_addr = 32'hFFFF0008; #1;
    chk("raddr_2", {25'd0, mem_raddr}, 32'd2);
    cpu_addr = 32'h0;
    reset = 1'b1;
    @(negedge clk);

    // tiny image
    base = wr_total;
    send_byte(8'h33);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13);
    repeat (3) @(negedge clk);
    chk("tiny_nwr", wr_total - base, 32'd1);
    chk("tiny_addr", {25'd0, wa[base]}, 32'd0);
    chk("tiny_data", wd[base], 32'h00000013);
    chk("tiny_done", {31'd0, load_done}, 32'd1);
    chk("tiny_hold", {31'd0, cpu_hold}, 32'd0);
    chk("tiny_err", {31'd0, load_err}, 32'd0);
    cpu_addr = 32'h4; #1;
    chk("tiny_fetch4", instr, 32'hCAFEF00D);
    cpu_addr = 32'h0; #1;
    chk("tiny_fetch0", instr, 32'h00000013);

    // bytes in DONE are ignored
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    repeat (2) @(negedge clk);
    chk("done_ign_nwr", wr_total - base, 32'd1);
    chk("done_ign_done", {31'd0, load_done}, 32'd1);

    // reload with a coincident SYNC byte: the byte is dropped
    reload = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    @(negedge clk);
    reload = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reload_hold", {31'd0, cpu_hold}, 32'd1);
    chk("reload_done", {31'd0, load_done}, 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (2) @(negedge clk);
    chk("drop_sync_err", {31'd0, load_err}, 32'd0);

    // bad checksum
    base = wr_total;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("badcs_nwr", wr_total - base, 32'd1);
    chk("badcs_data", wd[base], 32'h44332211);
    chk("badcs_err", {31'd0, load_err}, 32'd1);
    chk("badcs_hold", {31'd0, cpu_hold}, 32'd1);
    chk("badcs_instr", instr, 32'h00000013);
    pulse_reload();
    chk("badcs_clr", {31'd0, load_err}, 32'd0);

    // LEN = 0
    base = wr_total;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("len0_err", {31'd0, load_err}, 32'd1);
    chk("len0_nwr", wr_total - base, 32'd0);
    pulse_reload();

    // LEN = 129
    base = wr_total;
    send_byte(8'hA5); send_byte(8'h81); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    repeat (3) @(negedge clk);
    chk("len129_err", {31'd0, load_err}, 32'd1);
    chk("len129_nwr", wr_total - base, 32'd0);
    pulse_reload();

    // full 128-word image
    base = wr_total;
    cs = 8'h00;
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
    for (int i = 0; i < 128; i++) begin
      b0 = 8'(i);
      b1 = b0 ^ 8'h5A;
      send_byte(b0); send_byte(b1); send_byte(8'h00); send_byte(8'h80);
      cs = cs ^ b0 ^ b1 ^ 8'h80;
    end
    send_byte(cs);
    repeat (20) @(negedge clk);
    chk("full_nwr", wr_total - base, 32'd128);
    bad = 0;
    for (int i = 0; i < 128; i++) if (wa[base+i] !== 7'(i)) bad++;
    chk("full_order", bad, 32'd0);
    chk("full_w5", wd[base+5], 32'h80005F05);
    chk("full_w127", wd[base+127], 32'h8000257F);
    chk("full_done", {31'd0, load_done}, 32'd1);
    chk("full_err", {31'd0, load_err}, 32'd0);
    pulse_reload();

    // timeout: a byte at idle cycle 99 restarts the count
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (98) @(negedge clk);
    send_byte(8'hCC);
    repeat (99) @(negedge clk);
    chk("to_not_yet", {31'd0, load_err}, 32'd0);
    repeat (2) @(negedge clk);
    chk("to_err", {31'd0, load_err}, 32'd1);
    pulse_reload();

    // reset in the middle of DATA
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mid_rst_waddr", {25'd0, mem_waddr}, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_err", {31'd0, load_err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    base = wr_total;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h08);
    repeat (3) @(negedge clk);
    chk("post_rst_nwr", wr_total - base, 32'd1);
    chk("post_rst_data", wd[base], 32'h12345678);
    chk("post_rst_done", {31'd0, load_done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
